// File: rtl/ps2_key_controller_if.sv
// PS/2 key controller bus: raw keyboard pins in, decoded key events and movement levels out.
// The slave side is the controller; the master side drives the pins and consumes the decoded outputs.
interface ps2_key_controller_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] KeyCode;
    logic       KeyValid;
    logic       KeyBreak;
    logic       KeyExt;
    logic       FrameErr;
    logic       GoLeft;
    logic       GoRight;

    modport master (
        output PS2_CLK, PS2_DAT,
        input  KeyCode, KeyValid, KeyBreak, KeyExt, FrameErr, GoLeft, GoRight
    );

    modport slave (
        input  PS2_CLK, PS2_DAT,
        output KeyCode, KeyValid, KeyBreak, KeyExt, FrameErr, GoLeft, GoRight
    );
endinterface

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard framer and E0/F0 decoder driving held-key movement levels GoLeft/GoRight.
// Optional feature macro: PS2_PARITY_CHECK_EN (odd parity enforced when defined).
module ps2_key_controller #(
    parameter int          TIMEOUT_CYCLES = 10000,
    parameter logic [7:0]  LEFT_CODE      = 8'h6B,
    parameter logic [7:0]  RIGHT_CODE     = 8'h74
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    ps2_key_controller_if.slave   bus
);

    localparam int         TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0] EXT_PREFIX = 8'hE0;
    localparam logic [7:0] BRK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    // Sync flops reset high so an idle (high) bus produces no spurious edge.
    logic [1:0] pin_meta_reg, pin_sync_reg;
    logic       clk_sync_d_reg;
    logic       fall, dat_sync;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pin_meta_reg   <= 2'b11;
            pin_sync_reg   <= 2'b11;
            clk_sync_d_reg <= 1'b1;
        end else begin
            pin_meta_reg   <= {bus.PS2_DAT, bus.PS2_CLK};
            pin_sync_reg   <= pin_meta_reg;
            clk_sync_d_reg <= pin_sync_reg[0];
        end
    end

    assign fall     = clk_sync_d_reg & ~pin_sync_reg[0];
    assign dat_sync = pin_sync_reg[1];

    state_t         state_reg, state_next;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    logic [8:0]     shift_reg;
    logic [TW-1:0]  timer_reg;
    logic           timeout, shift_en, accept, frame_err;
    logic           parity_ok;
    logic [7:0]     rx_byte;

    assign timeout = (timer_reg == TW'(TIMEOUT_CYCLES - 1));
    assign rx_byte = shift_reg[7:0];

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^shift_reg;
`else
    logic parity_unused;
    assign parity_unused = shift_reg[8];
    assign parity_ok     = 1'b1;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 9'd0;
            timer_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            if (shift_en)
                shift_reg <= {dat_sync, shift_reg[8:1]};
            if (state_reg == ST_IDLE || fall)
                timer_reg <= '0;
            else
                timer_reg <= timer_reg + 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_en     = 1'b0;
        accept       = 1'b0;
        frame_err    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (fall && !dat_sync) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_en     = 1'b1;
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    shift_en   = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_next = ST_IDLE;
                    if (dat_sync && parity_ok)
                        accept = 1'b1;
                    else
                        frame_err = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A fall on the same cycle restarts the timer, so it wins over the timeout.
        if (state_reg != ST_IDLE && !fall && timeout) begin
            state_next = ST_IDLE;
            frame_err  = 1'b1;
        end
    end

    logic [7:0] key_code_reg;
    logic       key_valid_reg, key_break_reg, key_ext_reg, frame_err_reg;
    logic       ext_pend_reg, brk_pend_reg;
    logic       held_l_reg, held_r_reg, last_left_reg;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            key_code_reg  <= 8'h00;
            key_valid_reg <= 1'b0;
            key_break_reg <= 1'b0;
            key_ext_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            ext_pend_reg  <= 1'b0;
            brk_pend_reg  <= 1'b0;
            held_l_reg    <= 1'b0;
            held_r_reg    <= 1'b0;
            last_left_reg <= 1'b0;
        end else begin
            key_valid_reg <= 1'b0;
            frame_err_reg <= frame_err;
            if (frame_err) begin
                ext_pend_reg <= 1'b0;
                brk_pend_reg <= 1'b0;
            end else if (accept) begin
                if (rx_byte == EXT_PREFIX) begin
                    ext_pend_reg <= 1'b1;
                end else if (rx_byte == BRK_PREFIX) begin
                    brk_pend_reg <= 1'b1;
                end else begin
                    key_code_reg  <= rx_byte;
                    key_ext_reg   <= ext_pend_reg;
                    key_break_reg <= brk_pend_reg;
                    key_valid_reg <= 1'b1;
                    ext_pend_reg  <= 1'b0;
                    brk_pend_reg  <= 1'b0;
                    // Only extended arrow codes move the character; typematic makes are idempotent.
                    if (ext_pend_reg && rx_byte == LEFT_CODE) begin
                        held_l_reg <= ~brk_pend_reg;
                        if (!brk_pend_reg)
                            last_left_reg <= 1'b1;
                    end
                    if (ext_pend_reg && rx_byte == RIGHT_CODE) begin
                        held_r_reg <= ~brk_pend_reg;
                        if (!brk_pend_reg)
                            last_left_reg <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.KeyCode  = key_code_reg;
    assign bus.KeyValid = key_valid_reg;
    assign bus.KeyBreak = key_break_reg;
    assign bus.KeyExt   = key_ext_reg;
    assign bus.FrameErr = frame_err_reg;
    assign bus.GoLeft   = held_l_reg & (~held_r_reg | last_left_reg);
    assign bus.GoRight  = held_r_reg & (~held_l_reg | ~last_left_reg);

endmodule

// File: tb/tb_ps2_key_controller.sv
// Randomised frame-level bench for ps2_key_controller against a byte-stream reference model.
module tb_ps2_key_controller;

    localparam int T    = 300;
    localparam int HALF = 20;
    localparam int GAP  = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_key_controller_if bus();

    ps2_key_controller #(.TIMEOUT_CYCLES(T)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int kv_cnt = 0, err_cnt = 0, err_cyc = 0;
    int last_fall = 0;

    // Reference model state: pending prefixes and an ordered list of held arrow keys.
    int         exp_kv = 0, exp_err = 0;
    logic [7:0] exp_code = 8'h00;
    bit         exp_ext = 0, exp_brk = 0, m_ext = 0, m_brk = 0;
    logic [7:0] held[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.KeyValid === 1'b1) kv_cnt = kv_cnt + 1;
        if (bus.FrameErr === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit active_is(input logic [7:0] code);
        return held.size() > 0 && held[held.size()-1] == code;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; exp_ext = 0; exp_brk = 0; exp_code = 8'h00;
        held.delete();
    endtask

    task automatic model_err();
        exp_err++;
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            model_err();
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            exp_kv++;
            exp_code = b;
            exp_ext  = m_ext;
            exp_brk  = m_brk;
            if (m_ext && (b == 8'h6B || b == 8'h74)) begin
                for (int i = held.size() - 1; i >= 0; i--)
                    if (held[i] == b) held.delete(i);
                if (!m_brk) held.push_back(b);
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".kv"},    kv_cnt,       exp_kv);
        check_val({tag, ".err"},   err_cnt,      exp_err);
        check_val({tag, ".code"},  bus.KeyCode,  exp_code);
        check_val({tag, ".ext"},   bus.KeyExt,   exp_ext);
        check_val({tag, ".brk"},   bus.KeyBreak, exp_brk);
        check_val({tag, ".left"},  bus.GoLeft,   active_is(8'h6B));
        check_val({tag, ".right"}, bus.GoRight,  active_is(8'h74));
    endtask

    task automatic drive_bit(input logic v);
        bus.PS2_DAT = v;
        repeat (HALF) @(negedge clk);
        bus.PS2_CLK = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        bus.PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
        logic [10:0] bits;
        logic        p;
        bit          good;
        p = ~(^b);
        if (bad_par) p = ~p;
        bits = {~bad_stop, p, b, 1'b0};
        for (int i = 0; i < 11; i++) drive_bit(bits[i]);
        bus.PS2_DAT = 1'b1;
        repeat (GAP) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
        good = !bad_stop && !bad_par;
`else
        good = !bad_stop;
`endif
        model_frame(b, good);
        $display("frame %s byte=%02h bad_par=%0d bad_stop=%0d kv=%0d err=%0d code=%02h ext=%0d brk=%0d L=%0d R=%0d",
                 tag, b, bad_par, bad_stop, kv_cnt, err_cnt, bus.KeyCode, bus.KeyExt, bus.KeyBreak,
                 bus.GoLeft, bus.GoRight);
        check_state(tag);
    endtask

    initial begin
        int diff;
        logic [7:0] b;
        int r;
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst.code",  bus.KeyCode,  8'h00);
        check_val("rst.valid", bus.KeyValid, 1'b0);
        check_val("rst.ferr",  bus.FrameErr, 1'b0);
        check_val("rst.left",  bus.GoLeft,   1'b0);
        check_val("rst.right", bus.GoRight,  1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_state("idle");

        send_frame(8'h1C, 0, 0, "plain1C");
        send_frame(8'hE0, 0, 0, "e0");
        send_frame(8'h6B, 0, 0, "leftmake");
        send_frame(8'hE0, 0, 0, "e0");
        send_frame(8'hF0, 0, 0, "f0");
        send_frame(8'h6B, 0, 0, "leftbrk");
        send_frame(8'hE0, 0, 0, "e0");
        send_frame(8'h6B, 0, 0, "leftmake2");
        send_frame(8'hE0, 0, 0, "e0");
        send_frame(8'h74, 0, 0, "rightmake");
        send_frame(8'hE0, 0, 0, "e0");
        send_frame(8'hF0, 0, 0, "f0");
        send_frame(8'h74, 0, 0, "rightbrk");
        send_frame(8'hE0, 0, 0, "e0");
        send_frame(8'hF0, 0, 0, "f0");
        send_frame(8'h6B, 0, 0, "leftbrk2");

        // Stalled frame after an E0: timeout must drop it and forget the prefix.
        send_frame(8'hE0, 0, 0, "e0");
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)));
        bus.PS2_DAT = 1'b1;
        repeat (T + 20) @(negedge clk);
        model_err();
        diff = err_cyc - last_fall;
        check_val("timeout.err", err_cnt, exp_err);
        check_val("timeout.lat", (diff >= T && diff <= T + 6), 1);
        send_frame(8'h6B, 0, 0, "after_to");
        send_frame(8'h1C, 0, 0, "after_to1C");

        send_frame(8'hE0, 0, 0, "e0");
        send_frame(8'h6B, 1, 0, "badpar");
        send_frame(8'h6B, 0, 0, "after_par");
        send_frame(8'h1C, 0, 1, "badstop");

        for (int n = 0; n < 50; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    b = 8'hE0;
                2:       b = 8'hF0;
                3, 4:    b = 8'h6B;
                5, 6:    b = 8'h74;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_frame(b, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, "rand");
        end

        // Reset mid-frame while moving left.
        send_frame(8'hE0, 0, 0, "e0");
        send_frame(8'h6B, 0, 0, "pre_rst");
        check_val("pre_rst.left", bus.GoLeft, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check_val("midrst.left",  bus.GoLeft,   1'b0);
        check_val("midrst.right", bus.GoRight,  1'b0);
        check_val("midrst.code",  bus.KeyCode,  8'h00);
        check_val("midrst.ext",   bus.KeyExt,   1'b0);
        check_val("midrst.brk",   bus.KeyBreak, 1'b0);
        check_val("midrst.valid", bus.KeyValid, 1'b0);
        check_val("midrst.ferr",  bus.FrameErr, 1'b0);
        bus.PS2_DAT = 1'b1;
        bus.PS2_CLK = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 0, 0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
